// File: rtl/dice_gprf_pkg.sv
// dice_gprf_pkg
//   Shared definitions for the DICE CGRA general-purpose register file lane:
//   default widths/depths and the special-register select encoding.
package dice_gprf_pkg;

   localparam int DATA_WIDTH_DEF = 32;
   localparam int NUM_TID_DEF    = 512;
   localparam int MAX_CTA_ID_DEF = 65535;

   // Special-register select codes; 13..15 are unused and read as zero.
   typedef enum logic [3:0] {
      SPEC_TID_X    = 4'd0,
      SPEC_TID_Y    = 4'd1,
      SPEC_TID_Z    = 4'd2,
      SPEC_NTID_X   = 4'd3,
      SPEC_NTID_Y   = 4'd4,
      SPEC_NTID_Z   = 4'd5,
      SPEC_CTAID_X  = 4'd6,
      SPEC_CTAID_Y  = 4'd7,
      SPEC_CTAID_Z  = 4'd8,
      SPEC_NCTAID_X = 4'd9,
      SPEC_NCTAID_Y = 4'd10,
      SPEC_NCTAID_Z = 4'd11,
      SPEC_CONST    = 4'd12
   } spec_sel_e;

endpackage

// File: rtl/gprf_addr_conv.sv
// gprf_addr_conv
//   Combinational thread-id to bank-address conversion. Each address bit is
//   taken from the override value when its enable bit is set, otherwise from
//   the dispatched thread id.
// Ports:
//   tid      in  W  dispatched thread id
//   ovr_en   in  W  per-bit override enable
//   ovr_addr in  W  per-bit override value
//   addr     out W  resulting bank address
module gprf_addr_conv #(
   parameter int W = 9
) (
   input  logic [W-1:0] tid,
   input  logic [W-1:0] ovr_en,
   input  logic [W-1:0] ovr_addr,
   output logic [W-1:0] addr
);

   generate
      for (genvar gi = 0; gi < W; gi++) begin : g_bit
         assign addr[gi] = ovr_en[gi] ? ovr_addr[gi] : tid[gi];
      end
   endgenerate

endmodule

// File: rtl/dice_gprf_lane.sv
// dice_gprf_lane
//   One lane of the DICE CGRA GPRF: a NUM_TID x DATA_WIDTH bank with one read
//   and one write port (each with per-bit address override), plus a
//   special-register source. rd_data shows either the bank word or the
//   special value, one cycle after the request.
// Ports:
//   clk, clr                        clock, synchronous active-high reset
//   rd_en, rd_tid, rd_ovr_*         bank read request and address override
//   wr_en, wr_tid, wr_ovr_*, wr_data  bank write request
//   spec_rd_en, spec_sel            special-register read and select
//   const_data                      constant operand (select 12)
//   tid_*, ntid_*                   thread index / block dimensions
//   ctaid_*, nctaid_*               CTA index / grid dimensions
//   rd_data                         read result
module dice_gprf_lane
   import dice_gprf_pkg::*;
#(
   parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
   parameter int NUM_TID       = NUM_TID_DEF,
   parameter int MAX_CTA_ID    = MAX_CTA_ID_DEF,
   parameter int RF_ADDR_WIDTH = $clog2(NUM_TID),
   parameter int CTAID_WIDTH   = $clog2(MAX_CTA_ID)
) (
   input  logic                     clk,
   input  logic                     clr,
   input  logic                     rd_en,
   input  logic [RF_ADDR_WIDTH-1:0] rd_tid,
   input  logic [RF_ADDR_WIDTH-1:0] rd_ovr_en,
   input  logic [RF_ADDR_WIDTH-1:0] rd_ovr_addr,
   input  logic                     wr_en,
   input  logic [RF_ADDR_WIDTH-1:0] wr_tid,
   input  logic [RF_ADDR_WIDTH-1:0] wr_ovr_en,
   input  logic [RF_ADDR_WIDTH-1:0] wr_ovr_addr,
   input  logic [DATA_WIDTH-1:0]    wr_data,
   input  logic                     spec_rd_en,
   input  logic [3:0]               spec_sel,
   input  logic [DATA_WIDTH-1:0]    const_data,
   input  logic [RF_ADDR_WIDTH-1:0] tid_x,
   input  logic [RF_ADDR_WIDTH-1:0] tid_y,
   input  logic [RF_ADDR_WIDTH-1:0] tid_z,
   input  logic [RF_ADDR_WIDTH-1:0] ntid_x,
   input  logic [RF_ADDR_WIDTH-1:0] ntid_y,
   input  logic [RF_ADDR_WIDTH-1:0] ntid_z,
   input  logic [CTAID_WIDTH-1:0]   ctaid_x,
   input  logic [CTAID_WIDTH-1:0]   ctaid_y,
   input  logic [CTAID_WIDTH-1:0]   ctaid_z,
   input  logic [CTAID_WIDTH-1:0]   nctaid_x,
   input  logic [CTAID_WIDTH-1:0]   nctaid_y,
   input  logic [CTAID_WIDTH-1:0]   nctaid_z,
   output logic [DATA_WIDTH-1:0]    rd_data
);

   logic [RF_ADDR_WIDTH-1:0] rd_addr;
   logic [RF_ADDR_WIDTH-1:0] wr_addr;

   gprf_addr_conv #(.W(RF_ADDR_WIDTH)) u_rd_conv (
      .tid      (rd_tid),
      .ovr_en   (rd_ovr_en),
      .ovr_addr (rd_ovr_addr),
      .addr     (rd_addr)
   );

   gprf_addr_conv #(.W(RF_ADDR_WIDTH)) u_wr_conv (
      .tid      (wr_tid),
      .ovr_en   (wr_ovr_en),
      .ovr_addr (wr_ovr_addr),
      .addr     (wr_addr)
   );

   // ---------------- bank ----------------
   logic [DATA_WIDTH-1:0] mem [NUM_TID];
   logic [DATA_WIDTH-1:0] rf_q;

   // Memory is deliberately not reset so it maps onto block RAM; writes
   // proceed even while clr is asserted.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Registered read kept next to the array so the output register folds
   // into the RAM primitive; same-address read/write yields the old word.
   always_ff @(posedge clk) begin
      if (clr) begin
         rf_q <= '0;
      end else if (rd_en) begin
         rf_q <= mem[rd_addr];
      end
   end

   // ---------------- special registers ----------------
   spec_sel_e             spec_sel_e_w;
   logic [DATA_WIDTH-1:0] spec_val;
   logic [DATA_WIDTH-1:0] spec_d, spec_q;
   logic                  sel_d, sel_q;

   assign spec_sel_e_w = spec_sel_e'(spec_sel);

   always_comb begin
      spec_val = '0;
      case (spec_sel_e_w)
         SPEC_TID_X:    spec_val[RF_ADDR_WIDTH-1:0] = tid_x;
         SPEC_TID_Y:    spec_val[RF_ADDR_WIDTH-1:0] = tid_y;
         SPEC_TID_Z:    spec_val[RF_ADDR_WIDTH-1:0] = tid_z;
         SPEC_NTID_X:   spec_val[RF_ADDR_WIDTH-1:0] = ntid_x;
         SPEC_NTID_Y:   spec_val[RF_ADDR_WIDTH-1:0] = ntid_y;
         SPEC_NTID_Z:   spec_val[RF_ADDR_WIDTH-1:0] = ntid_z;
         SPEC_CTAID_X:  spec_val[CTAID_WIDTH-1:0]   = ctaid_x;
         SPEC_CTAID_Y:  spec_val[CTAID_WIDTH-1:0]   = ctaid_y;
         SPEC_CTAID_Z:  spec_val[CTAID_WIDTH-1:0]   = ctaid_z;
         SPEC_NCTAID_X: spec_val[CTAID_WIDTH-1:0]   = nctaid_x;
         SPEC_NCTAID_Y: spec_val[CTAID_WIDTH-1:0]   = nctaid_y;
         SPEC_NCTAID_Z: spec_val[CTAID_WIDTH-1:0]   = nctaid_z;
         SPEC_CONST:    spec_val                    = const_data;
         default:       spec_val                    = '0;
      endcase
   end

   always_comb begin
      spec_d = spec_rd_en ? spec_val : spec_q;
      // The source flag follows spec_rd_en every cycle, so an idle cycle
      // switches the output back to the held bank word.
      sel_d  = spec_rd_en;
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         spec_q <= '0;
         sel_q  <= 1'b0;
      end else begin
         spec_q <= spec_d;
         sel_q  <= sel_d;
      end
   end

   assign rd_data = sel_q ? spec_q : rf_q;

endmodule

// File: tb/tb_dice_gprf_lane.sv
module tb_dice_gprf_lane;

   localparam int DW = 32;
   localparam int AW = 9;
   localparam int CW = 16;
   localparam int DEPTH = 512;

   logic          clk = 1'b0;
   logic          clr;
   logic          rd_en, wr_en, spec_rd_en;
   logic [AW-1:0] rd_tid, rd_ovr_en, rd_ovr_addr;
   logic [AW-1:0] wr_tid, wr_ovr_en, wr_ovr_addr;
   logic [DW-1:0] wr_data, const_data;
   logic [3:0]    spec_sel;
   logic [AW-1:0] tid_x, tid_y, tid_z, ntid_x, ntid_y, ntid_z;
   logic [CW-1:0] ctaid_x, ctaid_y, ctaid_z, nctaid_x, nctaid_y, nctaid_z;
   logic [DW-1:0] rd_data;

   always #5 clk = ~clk;

   dice_gprf_lane dut (
      .clk(clk), .clr(clr),
      .rd_en(rd_en), .rd_tid(rd_tid), .rd_ovr_en(rd_ovr_en), .rd_ovr_addr(rd_ovr_addr),
      .wr_en(wr_en), .wr_tid(wr_tid), .wr_ovr_en(wr_ovr_en), .wr_ovr_addr(wr_ovr_addr),
      .wr_data(wr_data),
      .spec_rd_en(spec_rd_en), .spec_sel(spec_sel), .const_data(const_data),
      .tid_x(tid_x), .tid_y(tid_y), .tid_z(tid_z),
      .ntid_x(ntid_x), .ntid_y(ntid_y), .ntid_z(ntid_z),
      .ctaid_x(ctaid_x), .ctaid_y(ctaid_y), .ctaid_z(ctaid_z),
      .nctaid_x(nctaid_x), .nctaid_y(nctaid_y), .nctaid_z(nctaid_z),
      .rd_data(rd_data)
   );

   // ---------------- reference model ----------------
   logic [DW-1:0] m_mem [DEPTH];
   logic [DW-1:0] m_bank_out;   // last bank word read
   logic [DW-1:0] m_spec_out;   // last special value read
   logic          m_show_spec;  // previous cycle requested a special read

   typedef struct {
      string         tag;
      logic [DW-1:0] data;
   } exp_t;
   exp_t sb[$];

   int checks = 0;
   int errors = 0;

   function automatic logic [AW-1:0] eff_addr(input logic [AW-1:0] t, en, ov);
      logic [AW-1:0] a;
      for (int b = 0; b < AW; b++) a[b] = en[b] ? ov[b] : t[b];
      return a;
   endfunction

   function automatic logic [DW-1:0] spec_value(input int code);
      logic [DW-1:0] v;
      v = '0;
      case (code)
         0:  v = DW'(tid_x);
         1:  v = DW'(tid_y);
         2:  v = DW'(tid_z);
         3:  v = DW'(ntid_x);
         4:  v = DW'(ntid_y);
         5:  v = DW'(ntid_z);
         6:  v = DW'(ctaid_x);
         7:  v = DW'(ctaid_y);
         8:  v = DW'(ctaid_z);
         9:  v = DW'(nctaid_x);
         10: v = DW'(nctaid_y);
         11: v = DW'(nctaid_z);
         12: v = const_data;
         default: v = '0;
      endcase
      return v;
   endfunction

   // Apply the currently driven inputs to the model, queue the rd_data value
   // expected after the coming edge, then advance one clock.
   task automatic cyc(input string tag);
      logic [DW-1:0] old_word;
      old_word = m_mem[eff_addr(rd_tid, rd_ovr_en, rd_ovr_addr)];
      if (wr_en) m_mem[eff_addr(wr_tid, wr_ovr_en, wr_ovr_addr)] = wr_data;
      if (clr) begin
         m_bank_out  = '0;
         m_spec_out  = '0;
         m_show_spec = 1'b0;
      end else begin
         if (rd_en) m_bank_out = old_word;
         if (spec_rd_en) m_spec_out = spec_value(int'(spec_sel));
         m_show_spec = spec_rd_en;
      end
      sb.push_back('{tag: tag, data: m_show_spec ? m_spec_out : m_bank_out});
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      clr = 0; rd_en = 0; wr_en = 0; spec_rd_en = 0;
      rd_tid = '0; rd_ovr_en = '0; rd_ovr_addr = '0;
      wr_tid = '0; wr_ovr_en = '0; wr_ovr_addr = '0;
      wr_data = '0; spec_sel = '0;
   endtask

   task automatic do_write(input logic [AW-1:0] tid, input logic [DW-1:0] d, input string tag);
      idle(); wr_en = 1; wr_tid = tid; wr_data = d;
      cyc(tag);
   endtask

   task automatic do_read(input logic [AW-1:0] tid, input string tag);
      idle(); rd_en = 1; rd_tid = tid;
      cyc(tag);
   endtask

   task automatic do_spec(input int code, input string tag);
      idle(); spec_rd_en = 1; spec_sel = 4'(code);
      cyc(tag);
   endtask

   // ---------------- monitor ----------------
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (rd_data !== e.data) begin
               errors++;
               $display("FAIL %s: rd_data=%08h expected %08h", e.tag, rd_data, e.data);
            end else begin
               $display("ok   %s: rd_data=%08h", e.tag, rd_data);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      idle();
      const_data = '0;
      tid_x = '0; tid_y = '0; tid_z = '0; ntid_x = '0; ntid_y = '0; ntid_z = '0;
      ctaid_x = '0; ctaid_y = '0; ctaid_z = '0; nctaid_x = '0; nctaid_y = '0; nctaid_z = '0;
      m_bank_out = '0; m_spec_out = '0; m_show_spec = 1'b0;

      // reset
      clr = 1; cyc("reset0");
      clr = 1; cyc("reset1");

      // give every bank word a known value
      for (int a = 0; a < DEPTH; a++) do_write(AW'(a), $urandom, "init");

      // plain write then read
      do_write(9'd5, 32'hDEADBEEF, "wr5");
      do_read(9'd5, "rd5");
      idle(); cyc("hold5");

      // write with partial override: 0x003 merged with 0x0A0 on bits 8:4
      idle(); wr_en = 1; wr_tid = 9'h003; wr_ovr_en = 9'h1F0; wr_ovr_addr = 9'h0A0;
      wr_data = 32'h0BADF00D; cyc("wr_ovr");
      do_read(9'h0A3, "rd_0a3");
      // all-ones read override ignores rd_tid
      idle(); rd_en = 1; rd_tid = 9'h1FF; rd_ovr_en = 9'h1FF; rd_ovr_addr = 9'h005;
      cyc("rd_full_ovr");

      // special registers
      tid_y = 9'd7; ctaid_z = 16'h1234; const_data = 32'hCAFEF00D;
      do_spec(1, "spec_tid_y");
      do_spec(8, "spec_ctaid_z");
      do_spec(12, "spec_const");
      do_spec(14, "spec_unused14");
      idle(); cyc("back_to_bank");

      // same-cycle read/write returns old data
      do_write(9'd9, 32'h11, "wr9_old");
      idle(); rd_en = 1; rd_tid = 9'd9; wr_en = 1; wr_tid = 9'd9; wr_data = 32'h22;
      cyc("rdwr9_same");
      do_read(9'd9, "rd9_new");

      // alternating sources
      for (int i = 0; i < 6; i++) begin
         if (i % 2 == 0) do_spec(12, "alt_spec");
         else do_read(9'd5, "alt_bank");
      end

      // both strobes together: special wins
      idle(); rd_en = 1; rd_tid = 9'd9; spec_rd_en = 1; spec_sel = 4'd1; cyc("both_en");
      idle(); cyc("both_then_bank");

      // clear mid-stream, with a write during clear
      do_read(9'd5, "pre_clr");
      idle(); clr = 1; rd_en = 1; rd_tid = 9'd5; spec_rd_en = 1; spec_sel = 4'd12;
      wr_en = 1; wr_tid = 9'd77; wr_data = 32'h5A5A1234; cyc("clr");
      idle(); cyc("post_clr_idle");
      do_read(9'd5, "post_clr_rd5");
      do_read(9'd77, "wr_during_clr");

      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         idle();
         clr = ($urandom_range(0, 49) == 0);
         rd_en = $urandom_range(0, 1);
         wr_en = $urandom_range(0, 1);
         spec_rd_en = ($urandom_range(0, 2) == 0);
         rd_tid = AW'($urandom); wr_tid = AW'($urandom);
         rd_ovr_en = ($urandom_range(0, 1) == 1) ? AW'($urandom) : '0;
         wr_ovr_en = ($urandom_range(0, 1) == 1) ? AW'($urandom) : '0;
         rd_ovr_addr = AW'($urandom); wr_ovr_addr = AW'($urandom);
         wr_data = $urandom; spec_sel = 4'($urandom);
         const_data = $urandom;
         tid_x = AW'($urandom); tid_y = AW'($urandom); tid_z = AW'($urandom);
         ntid_x = AW'($urandom); ntid_y = AW'($urandom); ntid_z = AW'($urandom);
         ctaid_x = CW'($urandom); ctaid_y = CW'($urandom); ctaid_z = CW'($urandom);
         nctaid_x = CW'($urandom); nctaid_y = CW'($urandom); nctaid_z = CW'($urandom);
         cyc("rand");
      end

      idle();
      for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: pending=%0d required 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
